// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rsa_pkg
// Description : Shared constants and types for the RSA / Montgomery datapath.
//               RSA_N_W : default modulus width
//               MONT_W  : default Montgomery word width
//               ninv_state_t : control states of the n' calculator
// Revision    : 1.0 - initial release
// ============================================================================
package rsa_pkg;

    localparam int RSA_N_W = 4096;
    localparam int MONT_W  = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FINAL = 2'd2
    } ninv_state_t;

endpackage
`default_nettype wire

// File: rtl/mont_ninv_hensel_step.sv
`default_nettype none
// ============================================================================
// Module      : hensel_step
// Description : One bit of Hensel lifting. If bit i of the running product
//               t is set, the inverse gains bit i, and nl<<i is added to t
//               so that bit i of t clears.
// Ports       : i_t       running product nl*y mod 2^W
//               i_nl      low W bits of the modulus
//               i_i       bit index being resolved
//               o_t_next  updated running product
//               o_bit_set inverse bit i must be set
// Revision    : 1.0 - initial release
// ============================================================================
module hensel_step #(
    parameter int W     = 64,
    parameter int CNT_W = $clog2(W)
) (
    input  logic [W-1:0]     i_t,
    input  logic [W-1:0]     i_nl,
    input  logic [CNT_W-1:0] i_i,
    output logic [W-1:0]     o_t_next,
    output logic             o_bit_set
);

    logic w_bit_set;

    assign w_bit_set = i_t[i_i];
    assign o_bit_set = w_bit_set;
    // Carry out of bit W-1 is dropped: arithmetic is mod 2^W.
    assign o_t_next  = w_bit_set ? (i_t + (i_nl << i_i)) : i_t;

endmodule
`default_nettype wire

// File: rtl/mont_ninv.sv
`default_nettype none
// ============================================================================
// Module      : mont_ninv
// Description : Bit-serial Montgomery constant generator. Computes
//               n^-1 mod 2^W (neg=0) or -n^-1 mod 2^W (neg=1) from the low
//               W bits of n. Fixed latency: go at edge k -> valid after
//               edge k+W. Even n raises err one edge after go.
// Ports       : clk        rising-edge clock
//               rst_n      asynchronous active-low reset
//               go         start pulse, honoured only while not busy
//               neg        select negated inverse (latched with go)
//               n          modulus, only n[W-1:0] is used
//               modulo_inv result, held until next completion or reset
//               valid      result ready (cleared on accepted go)
//               err        last accepted n was even
//               busy       computation in progress
// Revision    : 1.0 - initial release
// ============================================================================
module mont_ninv
    import rsa_pkg::*;
#(
    parameter int N_W   = RSA_N_W,
    parameter int W     = MONT_W,
    parameter int CNT_W = $clog2(W)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           go,
    input  logic           neg,
    input  logic [N_W-1:0] n,
    output logic [W-1:0]   modulo_inv,
    output logic           valid,
    output logic           err,
    output logic           busy
);

    localparam logic [CNT_W-1:0] c_I_LAST = CNT_W'(W - 1);

    ninv_state_t      r_state;
    ninv_state_t      w_state_next;
    logic [W-1:0]     r_nl;
    logic             r_neg;
    logic [W-1:0]     r_y;
    logic [W-1:0]     r_t;
    logic [CNT_W-1:0] r_i;
    logic [W-1:0]     r_modulo_inv;
    logic             r_valid;
    logic             r_err;

    logic             w_accept;
    logic [W-1:0]     w_t_next;
    logic             w_bit_set;
    logic [W-1:0]     w_nl_in;

    assign w_nl_in  = n[W-1:0];
    // Being in IDLE is exactly "not busy", so go is only honoured there.
    assign w_accept = go && (r_state == IDLE);

    // Upper modulus bits do not influence the word-level inverse.
    generate
        if (N_W > W) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^n[N_W-1:W];
        end
    endgenerate

    hensel_step #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_hensel_step (
        .i_t       (r_t),
        .i_nl      (r_nl),
        .i_i       (r_i),
        .o_t_next  (w_t_next),
        .o_bit_set (w_bit_set)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_nl_in[0]) w_state_next = ITER;
            ITER:    if (r_i == c_I_LAST)        w_state_next = FINAL;
            FINAL:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        busy = (r_state != IDLE);
    end

    assign modulo_inv = r_modulo_inv;
    assign valid      = r_valid;
    assign err        = r_err;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nl         <= '0;
            r_neg        <= 1'b0;
            r_y          <= '0;
            r_t          <= '0;
            r_i          <= '0;
            r_modulo_inv <= '0;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_nl    <= w_nl_in;
                        r_neg   <= neg;
                        r_valid <= 1'b0;
                        r_err   <= ~w_nl_in[0];
                        if (w_nl_in[0]) begin
                            // y=1 is the inverse mod 2; t=nl*y has bit 0 set.
                            r_y <= W'(1);
                            r_t <= w_nl_in;
                            r_i <= CNT_W'(1);
                        end
                    end
                end
                ITER: begin
                    r_y <= r_y | (W'(w_bit_set) << r_i);
                    r_t <= w_t_next;
                    r_i <= r_i + CNT_W'(1);
                end
                FINAL: begin
                    r_modulo_inv <= r_neg ? (~r_y + W'(1)) : r_y;
                    r_valid      <= 1'b1;
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mont_ninv.sv
`default_nettype none
// ============================================================================
// Module      : tb_mont_ninv
// Description : Self-checking bench for mont_ninv at W=64, W=16 and W=2.
//               Expected results are queued when a go is driven and popped
//               when the instance raises valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mont_ninv;

    localparam int N64 = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic            go_a, neg_a, valid_a, err_a, busy_a;
    logic [N64-1:0]  n_a;
    logic [63:0]     mi_a;

    logic            go_b, neg_b, valid_b, err_b, busy_b;
    logic [31:0]     n_b;
    logic [15:0]     mi_b;

    logic            go_c, neg_c, valid_c, err_c, busy_c;
    logic [7:0]      n_c;
    logic [1:0]      mi_c;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];

    mont_ninv #(.N_W(N64), .W(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .go(go_a), .neg(neg_a), .n(n_a),
        .modulo_inv(mi_a), .valid(valid_a), .err(err_a), .busy(busy_a)
    );

    mont_ninv #(.N_W(32), .W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .go(go_b), .neg(neg_b), .n(n_b),
        .modulo_inv(mi_b), .valid(valid_b), .err(err_b), .busy(busy_b)
    );

    mont_ninv #(.N_W(8), .W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .go(go_c), .neg(neg_c), .n(n_c),
        .modulo_inv(mi_c), .valid(valid_c), .err(err_c), .busy(busy_c)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] wmask(input int w);
        return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    // Newton iteration x <- x*(2 - a*x): each step doubles the correct bits.
    function automatic logic [63:0] model_inv(input logic [63:0] a, input logic negv, input int w);
        logic [63:0] x;
        x = a;
        repeat (6) x = x * (64'd2 - a * x);
        if (negv) x = -x;
        return x & wmask(w);
    endfunction

    task automatic drive(input int sel, input logic [N64-1:0] nv, input logic negv, input logic g);
        case (sel)
            0:       begin go_a = g; n_a = nv;        neg_a = negv; end
            1:       begin go_b = g; n_b = nv[31:0];  neg_b = negv; end
            default: begin go_c = g; n_c = nv[7:0];   neg_c = negv; end
        endcase
    endtask

    function automatic logic o_valid(input int sel);
        return (sel == 0) ? valid_a : (sel == 1) ? valid_b : valid_c;
    endfunction
    function automatic logic o_err(input int sel);
        return (sel == 0) ? err_a : (sel == 1) ? err_b : err_c;
    endfunction
    function automatic logic o_busy(input int sel);
        return (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
    endfunction
    function automatic logic [63:0] o_mi(input int sel);
        return (sel == 0) ? mi_a : (sel == 1) ? {48'd0, mi_b} : {62'd0, mi_c};
    endfunction

    // One complete computation; optional go pulses injected while busy.
    task automatic run(input int sel, input int w, input logic [N64-1:0] nv,
                       input logic negv, input logic disturb,
                       input logic [63:0] expv, input string tag);
        int          cnt;
        logic [63:0] e;
        logic [63:0] prod;
        exp_q.push_back(expv);
        drive(sel, nv, negv, 1'b1);
        tick();
        drive(sel, nv, negv, 1'b0);
        check({tag, " accept busy"},  64'(o_busy(sel)),  64'd1);
        check({tag, " accept valid"}, 64'(o_valid(sel)), 64'd0);
        check({tag, " accept err"},   64'(o_err(sel)),   64'd0);
        cnt = 0;
        while (!o_valid(sel) && cnt < 4 * w + 8) begin
            if (disturb && (cnt == 4 || cnt == 29))
                drive(sel, N64'(5), ~negv, 1'b1);
            else
                drive(sel, nv, negv, 1'b0);
            tick();
            cnt++;
        end
        drive(sel, nv, negv, 1'b0);
        check({tag, " latency"}, 64'(cnt), 64'(w));
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
        check({tag, " result"}, o_mi(sel), e);
        check({tag, " done err"},  64'(o_err(sel)),  64'd0);
        check({tag, " done busy"}, 64'(o_busy(sel)), 64'd0);
        prod = (nv[63:0] * o_mi(sel)) & wmask(w);
        check({tag, " n*inv"}, prod, negv ? wmask(w) : 64'd1);
    endtask

    initial begin
        logic [N64-1:0] big;
        logic [63:0]    rv;
        logic           rneg;

        rst_n = 1'b0;
        go_a = 1'b0; neg_a = 1'b0; n_a = '0;
        go_b = 1'b0; neg_b = 1'b0; n_b = '0;
        go_c = 1'b0; neg_c = 1'b0; n_c = '0;
        #1;
        check("reset mi64",    mi_a, 64'd0);
        check("reset valid64", 64'(valid_a), 64'd0);
        check("reset err64",   64'(err_a),   64'd0);
        check("reset busy64",  64'(busy_a),  64'd0);
        check("reset mi16",    o_mi(1), 64'd0);
        check("reset mi2",     o_mi(2), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed W=64 results
        run(0, 64, N64'(3), 1'b1, 1'b0, 64'h5555_5555_5555_5555, "n3 neg");
        run(0, 64, N64'(3), 1'b0, 1'b0, 64'hAAAA_AAAA_AAAA_AAAB, "n3 pos");
        run(0, 64, N64'(1), 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, "n1 neg");
        big = '0;
        big[N64-1] = 1'b1;
        big[63:0]  = 64'hFFFF_FFFF_FFFF_FFFF;
        run(0, 64, big, 1'b1, 1'b0, 64'h0000_0000_0000_0001, "n big");

        // Even modulus: err next edge, no busy, result untouched
        drive(0, N64'(6), 1'b1, 1'b1);
        tick();
        drive(0, N64'(6), 1'b1, 1'b0);
        check("even err",   64'(err_a),   64'd1);
        check("even valid", 64'(valid_a), 64'd0);
        check("even busy",  64'(busy_a),  64'd0);
        check("even mi",    mi_a, 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("even busy hold", 64'(busy_a), 64'd0);
        end
        check("even err hold", 64'(err_a), 64'd1);

        // go pulses while busy must be ignored
        run(0, 64, N64'(3), 1'b1, 1'b1, 64'h5555_5555_5555_5555, "disturbed");
        // go right after valid
        run(0, 64, N64'(1), 1'b0, 1'b0, 64'h0000_0000_0000_0001, "restart");

        // Asynchronous reset mid-run
        drive(0, N64'(7), 1'b0, 1'b1);
        tick();
        drive(0, N64'(7), 1'b0, 1'b0);
        repeat (29) tick();
        check("midrun busy before", 64'(busy_a), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort mi",    mi_a, 64'd0);
        check("abort valid", 64'(valid_a), 64'd0);
        check("abort err",   64'(err_a),   64'd0);
        check("abort busy",  64'(busy_a),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 64, N64'(3), 1'b1, 1'b0, 64'h5555_5555_5555_5555, "after abort");

        // W=16 sweep
        run(1, 16, N64'(3), 1'b0, 1'b0, 64'hAAAB, "w16 n3");
        for (int v = 0; v < 1000; v++) begin
            rv   = {32'd0, $urandom} | 64'd1;
            rneg = 1'($urandom_range(0, 1));
            run(1, 16, N64'(rv), rneg, 1'b0, model_inv(rv, rneg, 16), "w16 rnd");
        end

        // W=2 sweep
        for (int v = 0; v < 1000; v++) begin
            rv   = {56'd0, 8'($urandom)} | 64'd1;
            rneg = 1'($urandom_range(0, 1));
            run(2, 2, N64'(rv), rneg, 1'b0, model_inv(rv, rneg, 2), "w2 rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
